// File: rtl/display_scan_scheduler_pkg.sv
// Shared definitions for the seven-segment scan scheduler: digit/segment
// geometry, the scan state encoding and small pattern/strobe helpers.
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 7;
    localparam int DIGIT_W    = 2;
    localparam int LOAD_W     = NUM_DIGITS * SEG_W;

    localparam logic [NUM_DIGITS-1:0] CTRL_ALL_OFF = 4'b1111;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } scan_state_e;

    // Extract the 7-bit segment pattern of one digit from a packed frame.
    function automatic logic [SEG_W-1:0] digit_pattern(
        input logic [LOAD_W-1:0]  frame,
        input logic [DIGIT_W-1:0] idx
    );
        logic [SEG_W-1:0] pat;
        case (idx)
            2'd0:    pat = frame[6:0];
            2'd1:    pat = frame[13:7];
            2'd2:    pat = frame[20:14];
            2'd3:    pat = frame[27:21];
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    // Active-low one-cold digit strobe for the selected digit.
    function automatic logic [NUM_DIGITS-1:0] digit_strobe(
        input logic [DIGIT_W-1:0] idx
    );
        logic [NUM_DIGITS-1:0] strobe;
        case (idx)
            2'd0:    strobe = 4'b1110;
            2'd1:    strobe = 4'b1101;
            2'd2:    strobe = 4'b1011;
            2'd3:    strobe = 4'b0111;
            default: strobe = CTRL_ALL_OFF;
        endcase
        return strobe;
    endfunction

endpackage

// File: rtl/display_scan_scheduler_if.sv
// Load handshake between the digit encoders (master) and the scan
// scheduler (slave): four packed segment patterns with valid/ready.
interface display_scan_scheduler_if;

    logic                           load_valid;
    logic                           load_ready;
    logic [display_pkg::LOAD_W-1:0] load_data;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );

endinterface

// File: rtl/display_scan_scheduler_slot_timer.sv
// Slot timer: counts the blank and on phases of each digit slot, steps the
// digit index 0..3 and flags the frame wrap (digit 3 -> digit 0). The wrap
// strobe is combinational so the top can swap buffers on the same edge that
// the timer re-enters the blank phase of digit 0.
module slot_timer
    import display_pkg::*;
#(
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic               clk,
    input  logic               reset,
    output scan_state_e        state,
    output logic [DIGIT_W-1:0] digit,
    output logic               frame_wrap,
    output logic               frame_start
);

    localparam int CNT_W = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;

    scan_state_e        state_r;
    logic [CNT_W-1:0]   slot_cnt_r;
    logic [DIGIT_W-1:0] digit_r;
    logic               frame_start_r;
    logic               blank_done_s;
    logic               on_done_s;
    logic               wrap_s;

    // Phase-end detection for the current state and the frame wrap strobe.
    always_comb begin
        blank_done_s = (state_r == S_BLANK) &&
                       (slot_cnt_r == CNT_W'(BLANK_CYCLES - 1));
        on_done_s    = (state_r == S_ON) &&
                       (slot_cnt_r == CNT_W'(SLOT_CYCLES - BLANK_CYCLES - 1));
        wrap_s       = on_done_s && (digit_r == DIGIT_W'(NUM_DIGITS - 1));
    end

    // Blank/on FSM with slot counter, digit stepping and frame pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= S_BLANK;
            slot_cnt_r    <= '0;
            digit_r       <= '0;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= wrap_s;
            case (state_r)
                S_BLANK: begin
                    if (blank_done_s) begin
                        state_r    <= S_ON;
                        slot_cnt_r <= '0;
                    end else begin
                        slot_cnt_r <= slot_cnt_r + CNT_W'(1);
                    end
                end
                S_ON: begin
                    if (on_done_s) begin
                        state_r    <= S_BLANK;
                        slot_cnt_r <= '0;
                        digit_r    <= digit_r + DIGIT_W'(1);
                    end else begin
                        slot_cnt_r <= slot_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r    <= S_BLANK;
                    slot_cnt_r <= '0;
                end
            endcase
        end
    end

    assign state       = state_r;
    assign digit       = digit_r;
    assign frame_wrap  = wrap_s;
    assign frame_start = frame_start_r;

endmodule

// File: rtl/display_scan_scheduler.sv
// Four-digit seven-segment scan scheduler. Accepts new patterns through a
// valid/ready handshake into a shadow buffer, promotes them to the active
// buffer only at frame boundaries, and drives registered segment/strobe
// pins with an anti-ghosting blank phase and PWM brightness per slot.
// Optional build macro: DISPLAY_DIGIT_MASK_EN adds a per-digit enable input
// sampled at frame boundaries.
module display_scan_scheduler
    import display_pkg::*;
#(
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BRIGHT_W     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    display_scan_scheduler_if.slave   load_if,
    input  logic [BRIGHT_W-1:0]       brightness,
`ifdef DISPLAY_DIGIT_MASK_EN
    input  logic [NUM_DIGITS-1:0]     digit_en,
`endif
    output logic [SEG_W-1:0]          seven_seg,
    output logic [NUM_DIGITS-1:0]     control,
    output logic                      frame_start
);

    scan_state_e           scan_state_s;
    logic [DIGIT_W-1:0]    digit_s;
    logic                  frame_wrap_s;
    logic                  frame_start_s;

    logic [LOAD_W-1:0]     shadow_r;
    logic [LOAD_W-1:0]     active_r;
    logic                  shadow_empty_r;
    logic [BRIGHT_W-1:0]   bright_r;
    logic [BRIGHT_W-1:0]   pwm_r;
    logic [SEG_W-1:0]      seven_seg_r;
    logic [NUM_DIGITS-1:0] control_r;

    logic                  accept_s;
    logic                  en_s;
    logic                  lit_s;

    slot_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk         (clk),
        .reset       (reset),
        .state       (scan_state_s),
        .digit       (digit_s),
        .frame_wrap  (frame_wrap_s),
        .frame_start (frame_start_s)
    );

`ifdef DISPLAY_DIGIT_MASK_EN
    logic [NUM_DIGITS-1:0] en_r;

    // Digit enables are frame-stable: sampled only at the frame boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_r <= 4'b1111;
        end else if (frame_wrap_s) begin
            en_r <= digit_en;
        end else begin
            en_r <= en_r;
        end
    end

    assign en_s = en_r[digit_s];
`else
    assign en_s = 1'b1;
`endif

    // Handshake acceptance and pixel-on decision for the current cycle.
    always_comb begin
        accept_s = load_if.load_valid && shadow_empty_r;
        lit_s    = (scan_state_s == S_ON) && (pwm_r < bright_r) && en_s;
    end

    // Shadow/active double buffer. An accept and a swap never coincide: an
    // accept needs an empty shadow, a swap needs a full one, so data taken
    // on the boundary edge waits in the shadow for the following frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_r       <= '0;
            active_r       <= '0;
            shadow_empty_r <= 1'b1;
        end else if (accept_s) begin
            shadow_r       <= load_if.load_data;
            shadow_empty_r <= 1'b0;
        end else if (frame_wrap_s && !shadow_empty_r) begin
            active_r       <= shadow_r;
            shadow_empty_r <= 1'b1;
        end else begin
            shadow_r       <= shadow_r;
            shadow_empty_r <= shadow_empty_r;
        end
    end

    // Brightness is frame-stable: latched only at the frame boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bright_r <= '0;
        end else if (frame_wrap_s) begin
            bright_r <= brightness;
        end else begin
            bright_r <= bright_r;
        end
    end

    // PWM counter restarts at zero on every on-phase entry and wraps freely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_r <= '0;
        end else if (scan_state_s == S_ON) begin
            pwm_r <= pwm_r + BRIGHT_W'(1);
        end else begin
            pwm_r <= '0;
        end
    end

    // Registered pin drivers: one cycle behind the FSM/PWM decision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seven_seg_r <= 7'h00;
            control_r   <= CTRL_ALL_OFF;
        end else if (lit_s) begin
            seven_seg_r <= digit_pattern(active_r, digit_s);
            control_r   <= digit_strobe(digit_s);
        end else begin
            seven_seg_r <= 7'h00;
            control_r   <= CTRL_ALL_OFF;
        end
    end

    assign load_if.load_ready = shadow_empty_r;
    assign seven_seg          = seven_seg_r;
    assign control            = control_r;
    assign frame_start        = frame_start_s;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Scoreboard bench for display_scan_scheduler with a time-based reference
// model: every lit pin cycle is predicted from the cycle index since reset.
module tb_display_scan_scheduler;
    import display_pkg::*;

    localparam int SLOT  = 20;
    localparam int BLANK = 4;
    localparam int BW    = 4;
    localparam int FRAME = SLOT * NUM_DIGITS;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [BW-1:0] brightness = '0;
    logic [6:0]    seven_seg;
    logic [3:0]    control;
    logic          frame_start;
`ifdef DISPLAY_DIGIT_MASK_EN
    logic [3:0]    digit_en = 4'b1111;
`endif

    display_scan_scheduler_if lif ();

    display_scan_scheduler #(
        .SLOT_CYCLES  (SLOT),
        .BLANK_CYCLES (BLANK),
        .BRIGHT_W     (BW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_if     (lif.slave),
        .brightness  (brightness),
`ifdef DISPLAY_DIGIT_MASK_EN
        .digit_en    (digit_en),
`endif
        .seven_seg   (seven_seg),
        .control     (control),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] ctrl;
        logic [6:0] seg;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cur_k  = 0;

    logic        m_full   = 1'b0;
    logic [27:0] m_shadow = '0;
    logic [27:0] m_active = '0;
    int          m_bright = 0;
    logic [3:0]  m_en     = 4'b1111;
    logic        exp_ready = 1'b1;

    // Reference model: interval k since reset; digit and phase follow from k.
    initial begin
        int   k, s, d;
        logic acc;
        exp_t e;
        forever begin
            @(posedge clk);
            if (!reset) begin
                cur_k = 0; m_full = 1'b0; m_shadow = '0; m_active = '0;
                m_bright = 0; m_en = 4'b1111; exp_ready = 1'b1;
                exp_q.delete();
            end else begin
                k = cur_k;
                s = k % SLOT;
                d = (k / SLOT) % NUM_DIGITS;
                if (s >= BLANK && ((s - BLANK) % (1 << BW)) < m_bright && m_en[d]) begin
                    e.cyc  = k + 1;
                    e.ctrl = 4'b1111 & ~(4'b0001 << d);
                    e.seg  = m_active[d*7 +: 7];
                    exp_q.push_back(e);
                end
                acc = lif.load_valid && !m_full;
                if ((k + 1) % FRAME == 0) begin
                    if (m_full) begin
                        m_active = m_shadow;
                        m_full   = 1'b0;
                    end
                    m_bright = int'(brightness);
`ifdef DISPLAY_DIGIT_MASK_EN
                    m_en = digit_en;
`endif
                end
                if (acc) begin
                    m_shadow = lif.load_data;
                    m_full   = 1'b1;
                end
                cur_k     = k + 1;
                exp_ready = !m_full;
            end
        end
    end

    // Monitor: compares pins on the falling edge against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                checks++;
                if (frame_start !== ((cur_k % FRAME == 0) && cur_k > 0)) begin
                    errors++;
                    $display("FAIL frame_start cyc=%0d got=%b", cur_k, frame_start);
                end
                checks++;
                if (lif.load_ready !== exp_ready) begin
                    errors++;
                    $display("FAIL load_ready cyc=%0d got=%b want=%b", cur_k, lif.load_ready, exp_ready);
                end
                while (exp_q.size() > 0 && exp_q[0].cyc < cur_k) begin
                    errors++;
                    $display("FAIL lit_stale cyc=%0d want_cyc=%0d", cur_k, exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
                checks++;
                if (control !== 4'b1111) begin
                    if (exp_q.size() == 0 || exp_q[0].cyc != cur_k) begin
                        errors++;
                        $display("FAIL lit_unexpected cyc=%0d control=%b seg=%h want dark", cur_k, control, seven_seg);
                    end else begin
                        if (control !== exp_q[0].ctrl || seven_seg !== exp_q[0].seg) begin
                            errors++;
                            $display("FAIL lit_value cyc=%0d control=%b seg=%h want control=%b seg=%h",
                                     cur_k, control, seven_seg, exp_q[0].ctrl, exp_q[0].seg);
                        end
                        void'(exp_q.pop_front());
                    end
                end else begin
                    if (seven_seg !== 7'h00) begin
                        errors++;
                        $display("FAIL dark_seg cyc=%0d seg=%h want 00", cur_k, seven_seg);
                    end
                    if (exp_q.size() > 0 && exp_q[0].cyc == cur_k) begin
                        errors++;
                        $display("FAIL lit_missing cyc=%0d control=%b want control=%b seg=%h",
                                 cur_k, control, exp_q[0].ctrl, exp_q[0].seg);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present data and hold it until the handshake completes (bounded).
    task automatic load(input logic [27:0] d);
        int n = 0;
        lif.load_valid = 1'b1;
        lif.load_data  = d;
        while (lif.load_ready !== 1'b1 && n < 4 * FRAME) begin
            tick();
            n++;
        end
        checks++;
        if (lif.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_timeout data=%h ready=%b want 1", d, lif.load_ready);
        end
        tick();
        lif.load_valid = 1'b0;
    endtask

    task automatic check_reset_pins(input string tag);
        checks++;
        if (control !== 4'b1111 || seven_seg !== 7'h00 || lif.load_ready !== 1'b1 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL %s control=%b seg=%h ready=%b fs=%b want 1111/00/1/0",
                     tag, control, seven_seg, lif.load_ready, frame_start);
        end
    endtask

    initial begin
        int n;
        lif.load_valid = 1'b0;
        lif.load_data  = '0;

        // Power-on reset.
        run(3);
        check_reset_pins("reset_init");
        reset = 1'b1;

        // Full brightness: two loads, the second stalls until the boundary.
        brightness = 4'd15;
        load(28'h0FFFFFFF);
        load(28'h000007F);
        while (cur_k < 3 * FRAME + 5) tick();

        // Dark for several frames, then half duty.
        brightness = 4'd0;
        run(4 * FRAME);
        brightness = 4'd8;
        run(2 * FRAME);

        // A mid-frame, then B stalls until A is promoted.
        brightness = 4'd12;
        while (cur_k % FRAME != 30) tick();
        load(28'h1234567);
        checks++;
        if (lif.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_load got=%b want 0", lif.load_ready);
        end
        load(28'h7654321);
        run(3 * FRAME);

        // Load presented exactly on the boundary cycle with an empty shadow.
        n = 0;
        while (cur_k % FRAME != FRAME - 1 && n < 2 * FRAME) begin
            tick();
            n++;
        end
        lif.load_valid = 1'b1;
        lif.load_data  = 28'h5A5A5A5;
        tick();
        lif.load_valid = 1'b0;
        run(3 * FRAME);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            lif.load_valid = ($urandom_range(0, 2) == 0);
            lif.load_data  = 28'($urandom);
            if ($urandom_range(0, 40) == 0) brightness = BW'($urandom);
`ifdef DISPLAY_DIGIT_MASK_EN
            if ($urandom_range(0, 200) == 0) digit_en = 4'($urandom);
            if (i == 1500) digit_en = 4'b0101;
`endif
            tick();
        end
        lif.load_valid = 1'b0;

        // Reset asserted mid-slot while lit with a full shadow.
        brightness = 4'd15;
`ifdef DISPLAY_DIGIT_MASK_EN
        digit_en = 4'b1111;
`endif
        run(2 * FRAME);
        load(28'h2AAAAAA);
        n = 0;
        while (control === 4'b1111 && n < 2 * FRAME) begin
            tick();
            n++;
        end
        checks++;
        if (control === 4'b1111 || lif.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset control=%b ready=%b want lit and 0", control, lif.load_ready);
        end
        #2;
        reset = 1'b0;
        #1;
        check_reset_pins("reset_async");
        for (int i = 0; i < 5; i++) begin
            tick();
            check_reset_pins("reset_hold");
        end
        reset = 1'b1;
        load(28'h3C3C3C3);
        run(3 * FRAME);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
